// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - instruction memory req/ack bus between the fetch sequencer and imem
interface pc_fetch_sequencer_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - FETCH/EXEC/HALT program-counter sequencer for the single-cycle MIPS core
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0040_0000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    pc_fetch_sequencer_if.master        imem,
    input  logic                        jump_i,
    input  logic                        branch_eq_i,
    input  logic                        branch_ne_i,
    input  logic                        zero_i,
    input  logic                        halt_i,
    output logic [31:0]                 instr_o,
    output logic                        instr_valid_o,
    output logic [31:0]                 pc_o,
    output logic [31:0]                 pc_plus4_o,
    output logic                        err_o
);

    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_t      state, next_state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  wait_cnt;
    logic        err;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        illegal;
    logic        taken;
    logic        timeout;

    assign pc_plus4   = pc + 32'd4;
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        next_pc    = pc_plus4;
        illegal    = 1'b0;
        taken      = 1'b0;
        timeout    = 1'b0;

        // Priority: jump, then the illegal beq+bne decode, then conditional branch.
        if (jump_i) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch_eq_i && branch_ne_i) begin
            illegal = 1'b1;
        end else begin
            taken = (branch_eq_i && zero_i) || (branch_ne_i && !zero_i);
            if (taken) begin
                next_pc = pc_plus4 + branch_off;
            end
        end

        case (state)
            FETCH: begin
                if (imem.imem_ack_i) begin
                    next_state = EXEC;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    next_state = HALT;
                    timeout    = 1'b1;
                end
            end
            EXEC:    next_state = halt_i ? HALT : FETCH;
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            instr    <= 32'd0;
            wait_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.imem_ack_i) begin
                        instr    <= imem.imem_data_i;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (timeout) begin
                            err <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    pc       <= next_pc;
                    wait_cnt <= 8'd0;
                    if (illegal) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by reset so the request drops immediately while reset is held, with no clock.
    assign imem.imem_req_o  = (state == FETCH) && reset;
    assign imem.imem_addr_o = pc;
    assign instr_o          = instr;
    assign instr_valid_o    = (state == EXEC);
    assign pc_o             = pc;
    assign pc_plus4_o       = pc_plus4;
    assign err_o            = err;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RPC  = 32'h0040_0000;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, reset2;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pc_fetch_sequencer_if bus ();
    pc_fetch_sequencer_if bus2 ();

    logic        jump, beq, bne, zero, halt;
    logic [31:0] instr, pc, pc4;
    logic        valid, err;
    logic [31:0] instr2, pc2, pc42;
    logic        valid2, err2;

    pc_fetch_sequencer #(.RESET_PC(RPC), .FETCH_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .imem(bus),
        .jump_i(jump), .branch_eq_i(beq), .branch_ne_i(bne), .zero_i(zero), .halt_i(halt),
        .instr_o(instr), .instr_valid_o(valid), .pc_o(pc), .pc_plus4_o(pc4), .err_o(err)
    );

    pc_fetch_sequencer #(.RESET_PC(RPC2)) dut2 (
        .clk(clk), .reset(reset2), .imem(bus2),
        .jump_i(1'b0), .branch_eq_i(1'b0), .branch_ne_i(1'b0), .zero_i(1'b0), .halt_i(1'b0),
        .instr_o(instr2), .instr_valid_o(valid2), .pc_o(pc2), .pc_plus4_o(pc42), .err_o(err2)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    // One instruction: fetch with 'waits' wait states, then EXEC with the given decoder flags.
    task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] word, input int waits,
                             input logic j, input logic be, input logic bn, input logic z, input logic h);
        int t0;
        logic [63:0] e;
        t0 = cyc;
        sb.push_back({exp_pc, word});
        for (int i = 0; i <= waits; i++) begin
            checks++;
            if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== exp_pc) begin
                errors++;
                $display("FAIL fetch_addr: req=%b addr=%h, required req=1 addr=%h", bus.imem_req_o, bus.imem_addr_o, exp_pc);
            end
            if (i == waits) begin
                bus.imem_ack_i  = 1'b1;
                bus.imem_data_i = word;
            end
            @(posedge clk); #1;
        end
        bus.imem_ack_i  = 1'b0;
        bus.imem_data_i = 32'hDEAD_BEEF;
        jump = j; beq = be; bne = bn; zero = z; halt = h;
        checks++;
        if (valid !== 1'b1 || bus.imem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL exec_state: valid=%b req=%b, required valid=1 req=0", valid, bus.imem_req_o);
        end else begin
            e = sb.pop_front();
            checks++;
            if ({pc, instr} !== e || pc4 !== e[63:32] + 32'd4) begin
                errors++;
                $display("FAIL exec_regs: pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                         pc, instr, pc4, e[63:32], e[31:0], e[63:32] + 32'd4);
            end
        end
        @(posedge clk); #1;
        jump = 0; beq = 0; bne = 0; zero = 0; halt = 0;
        checks++;
        if (cyc - t0 !== waits + 2) begin
            errors++;
            $display("FAIL instr_cycles: got %0d, required %0d", cyc - t0, waits + 2);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus.imem_req_o !== 1'b0 || valid !== 1'b0 || err !== 1'b0 || pc !== RPC ||
            pc4 !== RPC + 32'd4 || instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_main: req=%b valid=%b err=%b pc=%h pc4=%h instr=%h, required 0 0 0 %h %h 0",
                     bus.imem_req_o, valid, err, pc, pc4, instr, RPC, RPC + 32'd4);
        end
        checks++;
        if (bus2.imem_req_o !== 1'b0 || pc2 !== RPC2 || pc42 !== 32'd0 || instr2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_wrap: req=%b pc=%h pc4=%h instr=%h, required 0 fffffffc 0 0",
                     bus2.imem_req_o, pc2, pc42, instr2);
        end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_sequence;
        run_instr(32'h0040_0000, 32'h2008_0005, 0, 0, 0, 0, 0, 0);
        run_instr(32'h0040_0004, 32'h0000_0000, 1, 0, 0, 0, 0, 0);
        run_instr(32'h0040_0008, 32'h1109_0003, 0, 0, 1, 0, 0, 0);
        run_instr(32'h0040_000C, 32'h0000_0000, 2, 0, 0, 0, 0, 0);
        run_instr(32'h0040_0010, 32'h0810_0010, 0, 1, 0, 0, 0, 0);
        run_instr(32'h0040_0040, 32'h1509_FFFF, 1, 0, 0, 1, 0, 0);
        run_instr(32'h0040_0040, 32'h0810_0002, 0, 1, 0, 0, 0, 0);
        run_instr(32'h0040_0008, 32'h1109_0003, 3, 0, 1, 0, 1, 0);
        run_instr(32'h0040_0018, 32'h0000_0000, 0, 0, 0, 0, 0, 0);
        run_instr(32'h0040_001C, 32'h0000_0000, 0, 0, 0, 0, 0, 0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_before_illegal: err=%b, required 0", err);
        end
    endtask

    task automatic test_illegal_and_halt;
        run_instr(32'h0040_0020, 32'h0000_0000, 0, 0, 1, 1, 0, 0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_illegal: err=%b, required 1", err);
        end
        run_instr(32'h0040_0024, 32'h0000_0000, 1, 0, 0, 0, 0, 1);
        checks++;
        if (err !== 1'b1 || pc !== 32'h0040_0028) begin
            errors++;
            $display("FAIL halt_pc: err=%b pc=%h, required err=1 pc=00400028", err, pc);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.imem_req_o !== 1'b0 || valid !== 1'b0) begin
                errors++;
                $display("FAIL halted_idle: req=%b valid=%b, required 0 0", bus.imem_req_o, valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset;
        reset = 1'b0;
        #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        run_instr(RPC, 32'h0810_0004, 0, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0040_0010) begin
            errors++;
            $display("FAIL wait_addr: req=%b addr=%h, required req=1 addr=00400010", bus.imem_req_o, bus.imem_addr_o);
        end
        bus.imem_ack_i  = 1'b1;
        bus.imem_data_i = 32'h1234_5678;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_o !== 1'b0 || valid !== 1'b0 || err !== 1'b0 || pc !== RPC ||
            pc4 !== RPC + 32'd4 || instr !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: req=%b valid=%b err=%b pc=%h pc4=%h instr=%h, required 0 0 0 %h %h 0",
                     bus.imem_req_o, valid, err, pc, pc4, instr, RPC, RPC + 32'd4);
        end
        @(posedge clk); #1;
        bus.imem_ack_i = 1'b0;
        reset = 1'b1;
        #1;
        run_instr(RPC, 32'h2008_0005, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_timeout;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (bus.imem_req_o !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: req=%b err=%b, required req=1 err=0", k, bus.imem_req_o, err);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (err !== 1'b1 || bus.imem_req_o !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: err=%b req=%b valid=%b, required 1 0 0", err, bus.imem_req_o, valid);
        end
        bus.imem_ack_i  = 1'b1;
        bus.imem_data_i = 32'h0810_0010;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (valid !== 1'b0 || bus.imem_req_o !== 1'b0 || pc !== 32'h0040_0004 || instr !== 32'h2008_0005) begin
                errors++;
                $display("FAIL late_ack: valid=%b req=%b pc=%h instr=%h, required 0 0 00400004 20080005",
                         valid, bus.imem_req_o, pc, instr);
            end
        end
        bus.imem_ack_i = 1'b0;
    endtask

    task automatic test_wrap;
        @(posedge clk); #1;
        reset2 = 1'b1;
        #1;
        checks++;
        if (bus2.imem_req_o !== 1'b1 || bus2.imem_addr_o !== RPC2 || pc42 !== 32'd0) begin
            errors++;
            $display("FAIL wrap_first: req=%b addr=%h pc4=%h, required 1 fffffffc 0", bus2.imem_req_o, bus2.imem_addr_o, pc42);
        end
        bus2.imem_ack_i  = 1'b1;
        bus2.imem_data_i = 32'h0000_0000;
        @(posedge clk); #1;
        bus2.imem_ack_i = 1'b0;
        checks++;
        if (valid2 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_exec: valid=%b, required 1", valid2);
        end
        @(posedge clk); #1;
        checks++;
        if (bus2.imem_req_o !== 1'b1 || bus2.imem_addr_o !== 32'd0 || pc42 !== 32'd4 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_second: req=%b addr=%h pc4=%h err=%b, required 1 0 4 0",
                     bus2.imem_req_o, bus2.imem_addr_o, pc42, err2);
        end
    endtask

    initial begin
        reset = 1'b0; reset2 = 1'b0;
        jump = 0; beq = 0; bne = 0; zero = 0; halt = 0;
        bus.imem_ack_i = 1'b0;  bus.imem_data_i = 32'd0;
        bus2.imem_ack_i = 1'b0; bus2.imem_data_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_sequence;
        test_illegal_and_halt;
        test_async_reset;
        test_timeout;
        test_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
